// File: rtl/dacboard_pkg.sv
// Shared types and constants for the dacboard audio path.
// UART framing, sample geometry and assembler states.
package dacboard_pkg;

  localparam int SAMPLE_W               = 18;
  localparam int BYTES_PER_SAMPLE       = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int CLK_HZ                 = 12_000_000;
  localparam int BAUD                   = 115_200;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_LO  = 2'd1,
    GOT_MID = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small show-ahead FIFO with occupancy count.
// Head word is visible on data whenever empty is low.
module sample_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign level = count;
  assign data  = mem[rd_ptr];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_frame_assembler.sv
// Rebuilds 18-bit samples from 3-byte little-endian UART frames,
// drops bad/stalled frames and queues samples for the DAC driver.
module audio_frame_assembler
  import dacboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 8
) (
  input  logic                          CLK_IN,
  input  logic                          RST_i,
  input  logic [7:0]                    byte_i,
  input  logic                          byte_valid_i,
  output logic [SAMPLE_W-1:0]           sample_o,
  output logic                          sample_valid_o,
  input  logic                          sample_ready_i,
  output logic                          frame_err_o,
  output logic                          timeout_o,
  output logic                          overflow_o,
  output logic [CNT_W-1:0]              drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  fsm_state_t          state;
  logic [7:0]          lo;
  logic [7:0]          mid;
  logic [TW-1:0]       timer;
  logic                fifo_empty;
  logic                fifo_full;
  logic                byte_ok;
  logic                frame_done;
  logic                push;
  logic                pop;
  logic                err_evt;
  logic                to_evt;
  logic                ov_evt;
  logic [SAMPLE_W-1:0] push_data;

  assign sample_valid_o = !fifo_empty;
  assign push_data      = {byte_i[1:0], mid, lo};

  // Frame checks and drop events; a byte arriving always beats expiry.
  always_comb begin
    byte_ok    = (byte_i[7:2] == 6'd0);
    frame_done = byte_valid_i && (state == GOT_MID);
    push       = frame_done && byte_ok;
    err_evt    = frame_done && !byte_ok;
    to_evt     = !byte_valid_i && (state != IDLE) && (timer == T_LAST);
    pop        = sample_valid_o && sample_ready_i;
    ov_evt     = push && fifo_full && !pop;
  end

  // Frame FSM, inter-byte timer, event pulses and drop counter.
  always_ff @(posedge CLK_IN or posedge RST_i) begin
    if (RST_i) begin
      state        <= IDLE;
      lo           <= '0;
      mid          <= '0;
      timer        <= '0;
      frame_err_o  <= 1'b0;
      timeout_o    <= 1'b0;
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end else begin
      frame_err_o <= err_evt;
      timeout_o   <= to_evt;
      overflow_o  <= ov_evt;
      if ((err_evt || to_evt || ov_evt) && (drop_count_o != '1))
        drop_count_o <= drop_count_o + 1'b1;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (byte_valid_i) begin
            lo    <= byte_i;
            state <= GOT_LO;
          end
        end
        GOT_LO: begin
          if (byte_valid_i) begin
            mid   <= byte_i;
            timer <= '0;
            state <= GOT_MID;
          end else if (to_evt) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GOT_MID: begin
          if (byte_valid_i || to_evt) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK_IN),
    .rst       (RST_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .data      (sample_o),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level_o)
  );

endmodule

// File: tb/tb_audio_frame_assembler.sv
// Bench for audio_frame_assembler: scoreboard of expected samples,
// popped and compared whenever the DAC side takes a sample.
module tb_audio_frame_assembler;

  logic        CLK_IN = 1'b0;
  logic        RST_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic [17:0] sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic        frame_err_o;
  logic        timeout_o;
  logic        overflow_o;
  logic [7:0]  drop_count_o;
  logic [2:0]  level_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_err    = 0;
  int n_to     = 0;
  int n_ov     = 0;
  logic [17:0] exp_q[$];

  audio_frame_assembler dut (
    .CLK_IN         (CLK_IN),
    .RST_i          (RST_i),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .frame_err_o    (frame_err_o),
    .timeout_o      (timeout_o),
    .overflow_o     (overflow_o),
    .drop_count_o   (drop_count_o),
    .level_o        (level_o)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: count event pulses and score every accepted sample.
  always @(negedge CLK_IN) begin
    if (!RST_i) begin
      if (frame_err_o) n_err++;
      if (timeout_o) n_to++;
      if (overflow_o) n_ov++;
      if (sample_valid_o && sample_ready_i) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("sample", 32'(sample_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK_IN); #1;
    byte_i       = b;
    byte_valid_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK_IN); #1;
      byte_valid_i = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    idle(1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge CLK_IN);
    idle(2);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    RST_i          = 1'b1;
    byte_i         = 8'h00;
    byte_valid_i   = 1'b0;
    sample_ready_i = 1'b0;
    @(negedge CLK_IN);
    check("rst_valid", 32'(sample_valid_o), 32'd0);
    check("rst_sample", 32'(sample_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_drops", 32'(drop_count_o), 32'd0);
    check("rst_pulses", 32'({frame_err_o, timeout_o, overflow_o}), 32'd0);
    repeat (2) @(posedge CLK_IN);
    #1 RST_i = 1'b0;

    // Single frame, latency of one cycle after the third strobe.
    sample_ready_i = 1'b1;
    exp_q.push_back(18'h001B8);
    send_byte(8'hB8);
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge CLK_IN);
    check("lat_pre", 32'(sample_valid_o), 32'd0);
    idle(1);
    @(negedge CLK_IN);
    check("lat_post", 32'(sample_valid_o), 32'd1);
    check("lat_sample", 32'(sample_o), 32'h001B8);
    drain("drain_440");
    check("drops_440", 32'(drop_count_o), 32'd0);

    // Back-to-back frames, extremes of the sample range.
    exp_q.push_back(18'h3FFFF);
    exp_q.push_back(18'h00105);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h03);
    send_byte(8'h05); send_byte(8'h01); send_byte(8'h00);
    idle(1);
    drain("drain_b2b");
    check("b2b_events", 32'(n_err + n_to + n_ov), 32'd0);

    // Malformed third byte, then resync.
    send_frame(8'h12, 8'h34, 8'h04);
    idle(2);
    check("ferr_pulse", 32'(n_err), 32'd1);
    check("ferr_drops", 32'(drop_count_o), 32'd1);
    check("ferr_level", 32'(level_o), 32'd0);
    exp_q.push_back(18'h00125);
    send_frame(8'h25, 8'h01, 8'h00);
    drain("drain_resync");

    // Stall past the timeout, then a good frame.
    send_byte(8'h12);
    send_byte(8'h34);
    idle(4100);
    check("to_pulse", 32'(n_to), 32'd1);
    check("to_drops", 32'(drop_count_o), 32'd2);
    exp_q.push_back(18'h00149);
    send_frame(8'h49, 8'h01, 8'h00);
    drain("drain_after_to");

    // Third byte lands exactly when the timer would expire.
    exp_q.push_back(18'h03412);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(4095);
    send_byte(8'h00);
    idle(3);
    check("to_edge", 32'(n_to), 32'd1);
    drain("drain_edge");

    // Fill with ready low; fifth frame overflows.
    sample_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back({2'b01, 8'h20, 8'(8'h10 + k)});
      send_frame(8'(8'h10 + k), 8'h20, 8'h01);
    end
    idle(2);
    check("full_level", 32'(level_o), 32'd4);
    check("ov_pulse", 32'(n_ov), 32'd1);
    check("ov_drops", 32'(drop_count_o), 32'd3);
    check("full_head", 32'(sample_o), 32'h12010);

    // Push and pop together while full.
    exp_q.push_back(18'h2ABCD);
    send_byte(8'hCD);
    send_byte(8'hAB);
    send_byte(8'h02);
    sample_ready_i = 1'b1;
    @(posedge CLK_IN); #1;
    byte_valid_i   = 1'b0;
    sample_ready_i = 1'b0;
    idle(1);
    check("pp_level", 32'(level_o), 32'd4);
    check("pp_no_ov", 32'(n_ov), 32'd1);
    sample_ready_i = 1'b1;
    drain("drain_full");
    check("drain_level", 32'(level_o), 32'd0);

    // Reset mid-frame clears everything.
    send_byte(8'h12);
    send_byte(8'h34);
    idle(2);
    #2 RST_i = 1'b1;
    @(negedge CLK_IN);
    check("mrst_valid", 32'(sample_valid_o), 32'd0);
    check("mrst_sample", 32'(sample_o), 32'd0);
    check("mrst_level", 32'(level_o), 32'd0);
    check("mrst_drops", 32'(drop_count_o), 32'd0);
    check("mrst_pulses", 32'({frame_err_o, timeout_o, overflow_o}), 32'd0);
    @(posedge CLK_IN); #1 RST_i = 1'b0;
    exp_q.push_back(18'h00200);
    send_frame(8'h00, 8'h02, 8'h00);
    idle(20);
    drain("drain_post_rst");
    check("post_rst_events", 32'(n_err + n_to + n_ov), 32'd3);
    check("post_rst_drops", 32'(drop_count_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
